lcd_screen_sequencer: RTL and testbench

- Sequences the single-byte LCD write engine (host side: data, rs, start, done) to bring up a 16x2 HD44780-style character LCD and keep it refreshed.
- After reset it waits out the power-up time, then issues the fixed init command list.
- It then writes two 16-character lines fetched from an external character buffer.
- After that it idles until a refresh request, when it rewrites both lines without repeating init.

---
 rtl/lcd_screen_sequencer_if.sv | 13 +
 rtl/lcd_screen_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_lcd_screen_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_screen_sequencer_if.sv
// Byte-write handshake between the LCD screen sequencer and the
// single-byte LCD write engine. The sequencer is the master: it presents
// a byte with its register-select and pulses start; the engine answers
// with a done level.
interface lcd_screen_sequencer_if;
  logic [7:0] odata;   // byte to write
  logic       ors;     // 0 = command, 1 = character data
  logic       ostart;  // one-cycle start pulse
  logic       idone;   // done level from the engine

  modport master (output odata, ors, ostart, input idone);
  modport slave  (input odata, ors, ostart, output idone);
endinterface

// File: rtl/lcd_screen_sequencer.sv
// Brings up a 16x2 HD44780-style LCD through a single-byte write engine:
// power-up wait, fixed init command list, then both 16-character lines
// read from an external character buffer. Afterwards it idles and
// rewrites both lines (without init) on each refresh request; requests
// arriving while busy coalesce into one extra pass.
module lcd_screen_sequencer #(
  parameter int PWR_WAIT     = 1000000,  // cycles after reset before first command
  parameter int CMD_DELAY    = 2500,     // gap after each completed transfer
  parameter int CLR_DELAY    = 100000,   // gap after clear-display (0x01)
  parameter int DONE_TIMEOUT = 255,      // max wait for done before forcing completion
  parameter int CNT_W        = 20        // delay/timeout counter width
) (
  input  logic                        iclk,
  input  logic                        irst,
  input  logic                        irefresh,
  output logic [4:0]                  ochar_addr,
  input  logic [7:0]                  ichar_data,
  lcd_screen_sequencer_if.master      bus,
  output logic                        obusy,
  output logic                        oinit_done,
  output logic                        oerr
);

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DELAY,
    S_IDLE
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'd37;
  localparam logic [5:0] INIT_LAST = 6'd3;   // entry mode set ends the init list
  localparam logic [5:0] LINE0_CMD = 6'd4;   // refresh passes start at the 0x80 address set

  state_t           state;
  logic [5:0]       step;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             idone_q;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] gap;
  logic [5:0]       step_nxt;
  logic             done_rise;

  // Step 5..20 is line 0, 22..37 is line 1; everything else is a command.
  function automatic logic is_char(input logic [5:0] s);
    return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
  endfunction

  // Buffer address {line, col} for a character step.
  function automatic logic [4:0] char_addr(input logic [5:0] s);
    logic [5:0] col;
    if (s >= 6'd22) begin
      col = s - 6'd22;
      return {1'b1, col[3:0]};
    end
    col = s - 6'd5;
    return {1'b0, col[3:0]};
  endfunction

  // Fixed command bytes: function set, display on, clear, entry mode,
  // and the two DDRAM line addresses.
  function automatic logic [7:0] cmd_byte(input logic [5:0] s);
    case (s)
      6'd0:    return 8'h38;
      6'd1:    return 8'h0C;
      6'd2:    return 8'h01;
      6'd3:    return 8'h06;
      6'd4:    return 8'h80;
      6'd21:   return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  // Saturating increment so a long wait can never wrap back to zero.
  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  // Clear-display needs the long gap; every other transfer uses the short one.
  assign gap       = (bus.odata == 8'h01 && !bus.ors) ? CNT_W'(CLR_DELAY) : CNT_W'(CMD_DELAY);
  assign step_nxt  = step + 6'd1;
  // A done level left high by the previous transfer is not a completion.
  assign done_rise = bus.idone & ~idone_q;

  // Sequencer FSM with all outputs registered.
  // NOTE: every state and output register here uses <= so all of them
  // update together on the edge and no branch sees a half-updated value.
  always_ff @(posedge iclk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so it takes
    // effect on the first edge it is seen and aborts any transfer at once.
    if (irst) begin
      state      <= S_PWR;
      step       <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      idone_q    <= 1'b0;
      ochar_addr <= '0;
      bus.odata  <= '0;
      bus.ors    <= 1'b0;
      bus.ostart <= 1'b0;
      obusy      <= 1'b1;
      oinit_done <= 1'b0;
      oerr       <= 1'b0;
    end else begin
      idone_q <= bus.idone;

      // Requests seen while busy are remembered and served by one extra pass.
      if (irefresh && state != S_IDLE) begin
        pending <= 1'b1;
      end

      case (state)
        S_PWR: begin
          if (cnt_inc >= CNT_W'(PWR_WAIT)) begin
            state <= S_LOAD;
            step  <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_LOAD: begin
          // ochar_addr was set up on entry, so ichar_data is valid now.
          bus.odata <= is_char(step) ? ichar_data : cmd_byte(step);
          bus.ors   <= is_char(step);
          state     <= S_START;
        end

        S_START: begin
          bus.ostart <= 1'b1;
          cnt        <= '0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          bus.ostart <= 1'b0;
          if (done_rise || cnt_inc >= CNT_W'(DONE_TIMEOUT)) begin
            if (!done_rise) begin
              oerr <= 1'b1;
            end
            cnt   <= '0;
            state <= S_DELAY;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_DELAY: begin
          if (cnt_inc >= gap) begin
            cnt <= '0;
            if (step == INIT_LAST) begin
              oinit_done <= 1'b1;
            end
            if (step == LAST_STEP) begin
              state <= S_IDLE;
              obusy <= 1'b0;
            end else begin
              step  <= step_nxt;
              state <= S_LOAD;
              if (is_char(step_nxt)) begin
                ochar_addr <= char_addr(step_nxt);
              end
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_IDLE: begin
          if (irefresh || pending) begin
            pending <= 1'b0;
            step    <= LINE0_CMD;
            state   <= S_LOAD;
            obusy   <= 1'b1;
          end
        end

        default: begin
          state <= S_PWR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_screen_sequencer.sv
// Scoreboard bench for lcd_screen_sequencer. Stimulus pushes the expected
// byte stream; a monitor pops and compares on every ostart pulse. A small
// write-engine model answers each start with a done level after a few
// cycles, and can withhold done for one chosen transfer.
module tb_lcd_screen_sequencer;

  localparam int ENG_LAT = 3;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       init;   // expected oinit_done when this byte starts
    logic       err;    // expected oerr when this byte starts
  } exp_t;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       irefresh = 1'b0;
  logic [4:0] ochar_addr;
  logic [7:0] ichar_data;
  logic       obusy;
  logic       oinit_done;
  logic       oerr;

  lcd_screen_sequencer_if bus_if ();

  lcd_screen_sequencer #(
    .PWR_WAIT    (10),
    .CMD_DELAY   (4),
    .CLR_DELAY   (20),
    .DONE_TIMEOUT(8),
    .CNT_W       (20)
  ) dut (
    .iclk      (iclk),
    .irst      (irst),
    .irefresh  (irefresh),
    .ochar_addr(ochar_addr),
    .ichar_data(ichar_data),
    .bus       (bus_if.master),
    .obusy     (obusy),
    .oinit_done(oinit_done),
    .oerr      (oerr)
  );

  always #5 iclk = ~iclk;

  // Character buffer: 0x41 + address.
  assign ichar_data = 8'h41 + {3'b000, ochar_addr};

  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_starts = 0;
  int   cyc     = 0;
  int   done_cyc = 0;
  bit   hold_en = 1'b0;
  int   hold_idx = 0;
  exp_t sb[$];

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference byte for a step, written out from the LCD command list.
  function automatic exp_t ref_step(input int s, input bit init_pass, input bit err_after1);
    exp_t e;
    e.rs = 1'b0;
    e.data = 8'h00;
    if (s == 0) e.data = 8'h38;
    else if (s == 1) e.data = 8'h0C;
    else if (s == 2) e.data = 8'h01;
    else if (s == 3) e.data = 8'h06;
    else if (s == 4) e.data = 8'h80;
    else if (s == 21) e.data = 8'hC0;
    else if (s <= 20) begin e.rs = 1'b1; e.data = 8'(8'h41 + s - 5); end
    else begin e.rs = 1'b1; e.data = 8'(8'h51 + s - 22); end
    e.init = !(init_pass && s <= 3);
    e.err  = err_after1 && s >= 2;
    return e;
  endfunction

  task automatic push_steps(input int first, input int last, input bit init_pass, input bit err_after1);
    for (int s = first; s <= last; s++) sb.push_back(ref_step(s, init_pass, err_after1));
  endtask

  // Write-engine model: drop done on start, raise it ENG_LAT cycles later.
  initial begin
    int idx;
    int my;
    bus_if.idone = 1'b0;
    idx = 0;
    forever begin
      @(negedge iclk);
      if (irst) begin
        idx = 0;
      end else if (bus_if.ostart) begin
        bus_if.idone = 1'b0;
        my = idx;
        idx++;
        if (!(hold_en && my == hold_idx)) begin
          repeat (ENG_LAT) @(negedge iclk);
          if (!irst) begin
            bus_if.idone = 1'b1;
            done_cyc = cyc;
          end
        end
      end
    end
  end

  // Monitor: compare every start pulse against the head of the scoreboard.
  initial begin
    logic prev_start;
    exp_t e;
    exp_t prev_e;
    bit   prev_valid;
    prev_start = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge iclk);
      if (irst) begin
        prev_start = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (bus_if.ostart) begin
          check("start_width", 32'(prev_start), 32'd0);
          if (!prev_start) begin
            n_starts++;
            if (sb.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_start: got data %0h rs %0b, expected no transfer", bus_if.odata, bus_if.ors);
            end else begin
              e = sb.pop_front();
              check("data", 32'(bus_if.odata), 32'(e.data));
              check("rs", 32'(bus_if.ors), 32'(e.rs));
              check("init_done", 32'(oinit_done), 32'(e.init));
              check("err", 32'(oerr), 32'(e.err));
              if (prev_valid && !prev_e.rs && prev_e.data == 8'h01)
                check("clr_gap_ge20", 32'((cyc - done_cyc) >= 20), 32'd1);
              prev_e = e;
              prev_valid = 1'b1;
            end
          end
        end
        prev_start = bus_if.ostart;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_odata", 32'(bus_if.odata), 32'd0);
    check("rst_ors", 32'(bus_if.ors), 32'd0);
    check("rst_ostart", 32'(bus_if.ostart), 32'd0);
    check("rst_char_addr", 32'(ochar_addr), 32'd0);
    check("rst_obusy", 32'(obusy), 32'd1);
    check("rst_init_done", 32'(oinit_done), 32'd0);
    check("rst_oerr", 32'(oerr), 32'd0);
  endtask

  // Release reset and count cycles until the first start pulse.
  task automatic release_and_time_first_start();
    int n;
    irst = 1'b0;
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (!bus_if.ostart && n < 100);
    check("first_start_cycles", 32'(n), 32'd12);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge iclk);
      n++;
    end
    check("wait_starts_in_time", 32'(n_starts >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((obusy || sb.size() != 0) && n < budget) begin
      @(negedge iclk);
      n++;
    end
    check("idle_in_time", 32'(obusy), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_refresh();
    irefresh = 1'b1;
    @(negedge iclk);
    irefresh = 1'b0;
  endtask

  initial begin
    int base;
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    // Reset state.
    irst = 1'b1;
    repeat (3) @(negedge iclk);
    check_reset_values();

    // Power-up, init list and both lines.
    push_steps(0, 37, 1'b1, 1'b0);
    release_and_time_first_start();
    wait_idle(3000);
    check("pass1_starts", 32'(n_starts), 32'd38);
    check("init_done_sticky", 32'(oinit_done), 32'd1);
    check("no_err", 32'(oerr), 32'd0);

    // Refresh from idle: one 34-transfer pass starting at 0x80.
    repeat (5) @(negedge iclk);
    base = n_starts;
    push_steps(4, 37, 1'b0, 1'b0);
    pulse_refresh();
    check("busy_after_refresh", 32'(obusy), 32'd1);
    wait_idle(3000);
    check("refresh_starts", 32'(n_starts - base), 32'd34);

    // Three requests during line 0 coalesce into one extra pass.
    repeat (5) @(negedge iclk);
    base = n_starts;
    push_steps(4, 37, 1'b0, 1'b0);
    push_steps(4, 37, 1'b0, 1'b0);
    pulse_refresh();
    wait_starts(base + 3, 500);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (6) @(negedge iclk);
    end
    wait_idle(6000);
    repeat (60) @(negedge iclk);
    check("coalesced_starts", 32'(n_starts - base), 32'd68);
    check("stays_idle", 32'(obusy), 32'd0);

    // Reset during the wait of step 10 aborts and restarts from power-up.
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    base = n_starts;
    push_steps(0, 10, 1'b1, 1'b0);
    wait_starts(base + 11, 3000);
    @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    check_reset_values();
    repeat (2) @(negedge iclk);

    // Restart; the engine withholds done for step 1 to force a timeout.
    hold_en = 1'b1;
    hold_idx = 1;
    base = n_starts;
    push_steps(0, 37, 1'b1, 1'b1);
    release_and_time_first_start();
    wait_starts(base + 2, 500);
    repeat (7) @(negedge iclk);
    check("oerr_before_timeout", 32'(oerr), 32'd0);
    @(negedge iclk);
    check("oerr_at_timeout", 32'(oerr), 32'd1);
    wait_idle(3000);
    check("timeout_pass_starts", 32'(n_starts - base), 32'd38);
    check("oerr_sticky", 32'(oerr), 32'd1);
    hold_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
